dae_issue_unit: RTL and testbench

- Sequencer stage directly upstream of the 4-bit decode-and-execute ALU.
- Accepts 10-bit instructions over a valid/ready handshake and holds a 4-entry x 4-bit register file.
- Drives registered operands and opcode (rs, rt, sel) into the combinational execute stage, then captures its 4-bit result and writes it back.
- Exposes a combinational debug read port that feeds the seven-segment path.

---
 rtl/dae_issue_unit_pkg.sv | 53 +++++
 rtl/dae_issue_unit_if.sv | 19 +
 rtl/dae_issue_unit_regfile.sv | 44 ++++
 rtl/dae_issue_unit.sv | 152 +++++++++++++++
 tb/tb_dae_issue_unit.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dae_issue_unit_pkg.sv
// -----------------------------------------------------------------------------
// dae_issue_unit_pkg
// Shared definitions for the issue unit: datapath width, register count,
// instruction field positions, FSM state encodings and an instruction decoder.
// -----------------------------------------------------------------------------
package dae_issue_unit_pkg;

  localparam int DATA_W  = 4;
  localparam int NREG    = 4;
  localparam int AW      = 2;
  localparam int SEL_W   = 3;
  localparam int INSTR_W = 10;

  // Instruction field positions
  localparam int LD_BIT  = 9;
  localparam int SEL_MSB = 8;
  localparam int SEL_LSB = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 4;
  localparam int RS_MSB  = 3;
  localparam int RS_LSB  = 2;
  localparam int RT_MSB  = 1;
  localparam int RT_LSB  = 0;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic              ld;
    logic [SEL_W-1:0]  sel;
    logic [AW-1:0]     rd;
    logic [AW-1:0]     rs;
    logic [AW-1:0]     rt;
    logic [DATA_W-1:0] imm;
  } instr_t;

  // Split a raw instruction word into its fields (imm overlaps rs/rt).
  function automatic instr_t decode_instr(input logic [INSTR_W-1:0] w);
    instr_t d;
    d.ld  = w[LD_BIT];
    d.sel = w[SEL_MSB:SEL_LSB];
    d.rd  = w[RD_MSB:RD_LSB];
    d.rs  = w[RS_MSB:RS_LSB];
    d.rt  = w[RT_MSB:RT_LSB];
    d.imm = w[IMM_MSB:IMM_LSB];
    return d;
  endfunction

endpackage

// File: rtl/dae_issue_unit_if.sv
// -----------------------------------------------------------------------------
// dae_issue_unit_if
// Instruction valid/ready channel between an instruction producer and the
// issue unit.
//   instr_valid : producer offers an instruction
//   instr_ready : issue unit can accept
//   instr       : 10-bit instruction word
// Modports: master = producer, slave = issue unit.
// -----------------------------------------------------------------------------
interface dae_issue_unit_if;

  logic                                   instr_valid;
  logic                                   instr_ready;
  logic [dae_issue_unit_pkg::INSTR_W-1:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);

endinterface

// File: rtl/dae_issue_unit_regfile.sv
// -----------------------------------------------------------------------------
// dae_regfile
// 4 x 4-bit register file with one synchronous write port and three
// asynchronous read ports (rs, rt, debug). Cleared asynchronously on rst.
//   clk, rst       : clock, async active-high reset
//   we_i/waddr_i/wdata_i : write port
//   rs_addr_i/rs_data_o, rt_addr_i/rt_data_o, dbg_addr_i/dbg_data_o : reads
// -----------------------------------------------------------------------------
module dae_regfile
  import dae_issue_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     rs_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  input  logic [AW-1:0]     rt_addr_i,
  output logic [DATA_W-1:0] rt_data_o,
  input  logic [AW-1:0]     dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] mem_q [NREG];

  // Register storage: async clear, single synchronous write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see the pre-edge value, so a source that equals the destination
  // is read before writeback.
  assign rs_data_o  = mem_q[rs_addr_i];
  assign rt_data_o  = mem_q[rt_addr_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/dae_issue_unit.sv
// -----------------------------------------------------------------------------
// dae_issue_unit
// Issue/sequencer stage in front of the combinational 4-bit execute stage.
// Accepts one instruction at a time (IDLE -> EXEC -> DONE for ALU ops,
// IDLE -> DONE for loads), drives registered operands/opcode to the execute
// stage, writes its result back and counts retired instructions.
//   clk, rst    : clock, async active-high reset
//   instr_if    : instruction valid/ready channel (slave side)
//   exec_rs_o, exec_rt_o, exec_sel_o : registered operands/opcode to execute
//   exec_rd_i   : execute-stage result, sampled at the EXEC closing edge
//   done_o      : one-cycle retire pulse
//   result_o    : value written by the last retired instruction
//   retired_o   : wrapping retired-instruction count
//   dbg_addr_i / dbg_data_o : combinational debug read of the register file
// -----------------------------------------------------------------------------
module dae_issue_unit
  import dae_issue_unit_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  dae_issue_unit_if.slave     instr_if,
  output logic [DATA_W-1:0]   exec_rs_o,
  output logic [DATA_W-1:0]   exec_rt_o,
  output logic [SEL_W-1:0]    exec_sel_o,
  input  logic [DATA_W-1:0]   exec_rd_i,
  output logic                done_o,
  output logic [DATA_W-1:0]   result_o,
  output logic [CNT_W-1:0]    retired_o,
  input  logic [AW-1:0]       dbg_addr_i,
  output logic [DATA_W-1:0]   dbg_data_o
);

  logic [1:0]        state_q,   state_d;
  logic [AW-1:0]     rd_q,      rd_d;
  logic [DATA_W-1:0] exec_rs_q, exec_rs_d;
  logic [DATA_W-1:0] exec_rt_q, exec_rt_d;
  logic [SEL_W-1:0]  exec_sel_q, exec_sel_d;
  logic [DATA_W-1:0] result_q,  result_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              done_q,    done_d;

  instr_t            dec_s;
  logic              hs_s;
  logic              we_s;
  logic [AW-1:0]     waddr_s;
  logic [DATA_W-1:0] wdata_s;
  logic [DATA_W-1:0] rs_data_s;
  logic [DATA_W-1:0] rt_data_s;

  assign dec_s                = decode_instr(instr_if.instr);
  assign instr_if.instr_ready = (state_q == ST_IDLE);
  assign hs_s                 = instr_if.instr_valid & (state_q == ST_IDLE);

  dae_regfile u_regfile (
    .clk        (clk),
    .rst        (rst),
    .we_i       (we_s),
    .waddr_i    (waddr_s),
    .wdata_i    (wdata_s),
    .rs_addr_i  (dec_s.rs),
    .rs_data_o  (rs_data_s),
    .rt_addr_i  (dec_s.rt),
    .rt_data_o  (rt_data_s),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o)
  );

  // Next-state, operand capture and register-file write control.
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    exec_rs_d  = exec_rs_q;
    exec_rt_d  = exec_rt_q;
    exec_sel_d = exec_sel_q;
    result_d   = result_q;
    retired_d  = retired_q;
    we_s       = 1'b0;
    waddr_s    = rd_q;
    wdata_s    = exec_rd_i;
    case (state_q)
      ST_IDLE: begin
        if (hs_s) begin
          if (dec_s.ld) begin
            // Load: write immediate directly, execute outputs untouched.
            we_s     = 1'b1;
            waddr_s  = dec_s.rd;
            wdata_s  = dec_s.imm;
            result_d = dec_s.imm;
            state_d  = ST_DONE;
          end else begin
            exec_rs_d  = rs_data_s;
            exec_rt_d  = rt_data_s;
            exec_sel_d = dec_s.sel;
            rd_d       = dec_s.rd;
            state_d    = ST_EXEC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        we_s     = 1'b1;
        waddr_s  = rd_q;
        wdata_s  = exec_rd_i;
        result_d = exec_rd_i;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // done is registered so it is high exactly while in DONE.
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_q       <= {AW{1'b0}};
      exec_rs_q  <= {DATA_W{1'b0}};
      exec_rt_q  <= {DATA_W{1'b0}};
      exec_sel_q <= {SEL_W{1'b0}};
      result_q   <= {DATA_W{1'b0}};
      retired_q  <= {CNT_W{1'b0}};
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      exec_rs_q  <= exec_rs_d;
      exec_rt_q  <= exec_rt_d;
      exec_sel_q <= exec_sel_d;
      result_q   <= result_d;
      retired_q  <= retired_d;
      done_q     <= done_d;
    end
  end

  assign exec_rs_o  = exec_rs_q;
  assign exec_rt_o  = exec_rt_q;
  assign exec_sel_o = exec_sel_q;
  assign result_o   = result_q;
  assign retired_o  = retired_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_dae_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_dae_issue_unit
// Directed bench for dae_issue_unit with a behavioural execute stage
// (sel0 = sub, sel1 = add).
// -----------------------------------------------------------------------------
module tb_dae_issue_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] exec_rs, exec_rt, exec_rd, result, dbg_data;
  logic [2:0] exec_sel;
  logic       done;
  logic [7:0] retired;
  logic [1:0] dbg_addr;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int exp_ret = 0;

  dae_issue_unit_if ifc ();

  dae_issue_unit #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_if   (ifc),
    .exec_rs_o  (exec_rs),
    .exec_rt_o  (exec_rt),
    .exec_sel_o (exec_sel),
    .exec_rd_i  (exec_rd),
    .done_o     (done),
    .result_o   (result),
    .retired_o  (retired),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  always #5 clk = ~clk;

  // Execute stage model.
  always_comb begin
    case (exec_sel)
      3'd0:    exec_rd = exec_rs - exec_rt;
      3'd1:    exec_rd = exec_rs + exec_rt;
      3'd2:    exec_rd = exec_rs & exec_rt;
      3'd3:    exec_rd = exec_rs | exec_rt;
      3'd4:    exec_rd = exec_rs ^ exec_rt;
      3'd5:    exec_rd = ~exec_rs;
      3'd6:    exec_rd = exec_rs;
      default: exec_rd = exec_rt;
    endcase
  end

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] alu_w(input logic [2:0] sel, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [1:0] rt);
    return {1'b0, sel, rd, rs, rt};
  endfunction

  function automatic logic [9:0] ld_w(input logic [1:0] rd, input logic [3:0] imm);
    return {1'b1, 3'b000, rd, imm};
  endfunction

  task automatic read_dbg(input logic [1:0] a, output logic [3:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  // Offer w, wait (bounded) for acceptance; returns #1 after the handshake edge.
  task automatic send(input logic [9:0] w);
    int n = 0;
    @(negedge clk);
    ifc.instr_valid = 1'b1;
    ifc.instr       = w;
    while (!ifc.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_bound", (n < 20), 1);
    @(posedge clk);
    #1;
    ifc.instr_valid = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] rd, input logic [3:0] imm);
    logic [3:0] v;
    int d0 = done_cnt;
    send(ld_w(rd, imm));
    check_eq("ld_done_hi", done, 1);
    check_eq("ld_ready_lo", ifc.instr_ready, 0);
    check_eq("ld_result", result, imm);
    read_dbg(rd, v);
    check_eq("ld_dbg", v, imm);
    @(posedge clk);
    #1;
    exp_ret++;
    check_eq("ld_done_lo", done, 0);
    check_eq("ld_retired", retired, exp_ret[7:0]);
    check_eq("ld_done_cnt", done_cnt - d0, 1);
  endtask

  task automatic do_alu(input logic [2:0] sel, input logic [1:0] rd, input logic [1:0] rs,
                        input logic [1:0] rt, input logic [3:0] ea, input logic [3:0] eb,
                        input logic [3:0] eres);
    logic [3:0] v;
    send(alu_w(sel, rd, rs, rt));
    check_eq("alu_exec_rs", exec_rs, ea);
    check_eq("alu_exec_rt", exec_rt, eb);
    check_eq("alu_exec_sel", exec_sel, sel);
    check_eq("alu_exec_done_lo", done, 0);
    check_eq("alu_exec_ready_lo", ifc.instr_ready, 0);
    @(posedge clk);
    #1;
    check_eq("alu_done_hi", done, 1);
    check_eq("alu_result", result, eres);
    read_dbg(rd, v);
    check_eq("alu_dbg", v, eres);
    @(posedge clk);
    #1;
    exp_ret++;
    check_eq("alu_done_lo", done, 0);
    check_eq("alu_retired", retired, exp_ret[7:0]);
  endtask

  initial begin
    logic [3:0] v;
    logic [9:0] seq [4];
    int d0, cyc, idx;
    logic take;

    rst = 1'b1;
    ifc.instr_valid = 1'b0;
    ifc.instr = 10'd0;
    dbg_addr = 2'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_exec_rs", exec_rs, 0);
    check_eq("rst_exec_sel", exec_sel, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_retired", retired, 0);
    check_eq("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_ready", ifc.instr_ready, 1);

    // Reset in the middle of an add r2 = r0 + r0
    do_load(2'd0, 4'd5);
    d0 = done_cnt;
    send(alu_w(3'd1, 2'd2, 2'd0, 2'd0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    read_dbg(2'd2, v);
    check_eq("midrst_r2", v, 0);
    read_dbg(2'd0, v);
    check_eq("midrst_r0", v, 0);
    check_eq("midrst_retired", retired, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_ret = 0;
    #1;
    check_eq("midrst_ready", ifc.instr_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("midrst_no_done", done_cnt - d0, 0);
    check_eq("midrst_retired2", retired, 0);

    // Loads and ALU ops
    do_load(2'd0, 4'd5);
    do_load(2'd1, 4'd3);
    read_dbg(2'd0, v);
    check_eq("dbg_r0", v, 5);
    check_eq("retired_two", retired, 2);
    do_alu(3'd1, 2'd2, 2'd0, 2'd1, 4'd5, 4'd3, 4'd8);
    do_alu(3'd0, 2'd3, 2'd1, 2'd0, 4'd3, 4'd5, 4'hE);
    do_alu(3'd0, 2'd0, 2'd0, 2'd0, 4'd5, 4'd5, 4'd0);
    do_alu(3'd4, 2'd1, 2'd3, 2'd2, 4'hE, 4'd8, 4'd6);

    // Back-to-back with instr_valid held high
    seq[0] = ld_w(2'd1, 4'd9);
    seq[1] = alu_w(3'd1, 2'd2, 2'd1, 2'd1);
    seq[2] = ld_w(2'd3, 4'd4);
    seq[3] = alu_w(3'd0, 2'd0, 2'd3, 2'd1);
    d0 = done_cnt;
    cyc = 0;
    idx = 0;
    @(negedge clk);
    ifc.instr_valid = 1'b1;
    ifc.instr = seq[0];
    while (idx < 4 && cyc < 40) begin
      take = ifc.instr_ready;
      if (take) ifc.instr = seq[idx];
      @(posedge clk);
      #1;
      cyc++;
      if (take) begin
        idx++;
        check_eq("b2b_ready_lo_after_accept", ifc.instr_ready, 0);
      end
      @(negedge clk);
    end
    ifc.instr_valid = 1'b0;
    check_eq("b2b_accept_edges", cyc, 8);
    repeat (3) @(posedge clk);
    #1;
    exp_ret += 4;
    check_eq("b2b_done_cnt", done_cnt - d0, 4);
    check_eq("b2b_retired", retired, exp_ret[7:0]);
    read_dbg(2'd1, v);
    check_eq("b2b_r1", v, 9);
    read_dbg(2'd2, v);
    check_eq("b2b_r2", v, 2);
    read_dbg(2'd3, v);
    check_eq("b2b_r3", v, 4);
    read_dbg(2'd0, v);
    check_eq("b2b_r0", v, 4'hB);

    // 256 loads: retired wraps to 0
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 255; i++) begin
      send(ld_w(i[1:0], i[3:0]));
    end
    @(posedge clk);
    #1;
    check_eq("wrap_255", retired, 8'd255);
    send(ld_w(2'd3, 4'd7));
    @(posedge clk);
    #1;
    check_eq("wrap_zero", retired, 0);
    check_eq("wrap_done_cnt", done_cnt - d0, 256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
